// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU select/enable interface.
package alu_pkg;

   // funct7 codes routed to each ALU; the issue-side select logic uses the same values.
   localparam logic [6:0] BASE_F7  = 7'h00;
   localparam logic [6:0] EXTRA_F7 = 7'h20;

   // Collector FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } alu_state_e;

   // Which ALU owns the op in flight.
   typedef enum logic {
      SEL_BASE  = 1'b0,
      SEL_EXTRA = 1'b1
   } alu_sel_e;

endpackage

// File: rtl/alu_timeout_ctr.sv
// Cycle counter that flags a hung ALU after TIMEOUT cycles of waiting.
module alu_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Clear on a new op; count up while waiting, holding at the last value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/alu_result_collect.sv
// Issues one ALU op at a time, waits for the selected unit's done and hands the
// result to writeback; reports illegal funct7 and unanswered ops.
//
// Handshakes: issue and writeback are valid/ready. A transfer happens on a rising
// edge where valid and ready are both high; valid, once raised by the sender, holds
// its payload stable until that edge. base_done/extra_done are 1-cycle pulses with
// no back-pressure.
module alu_result_collect
   import alu_pkg::*;
#(
   parameter int         XLEN     = 32,
   parameter int         TIMEOUT  = 16,
   parameter logic [6:0] BASE_F7  = alu_pkg::BASE_F7,
   parameter logic [6:0] EXTRA_F7 = alu_pkg::EXTRA_F7
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [6:0]      issue_funct7,
   input  logic [4:0]      issue_rd,
   output logic            base_enable,
   output logic            extra_enable,
   input  logic            base_done,
   input  logic [XLEN-1:0] base_result,
   input  logic            extra_done,
   input  logic [XLEN-1:0] extra_result,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            err_illegal,
   output logic            err_timeout,
   output alu_state_e      dbg_state
);

   alu_state_e state_q, state_d;
   alu_sel_e   sel_q;
   logic [4:0] rd_q;
   logic [XLEN-1:0] data_q;

   logic accept, legal, sel_done, expired, capture;
   logic base_en_d, extra_en_d, err_ill_d, err_to_d;

   assign accept   = issue_valid && issue_ready;
   assign legal    = (issue_funct7 == BASE_F7) || (issue_funct7 == EXTRA_F7);
   assign sel_done = (sel_q == SEL_BASE) ? base_done : extra_done;

   alu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept),
      .run     (state_q == WAIT),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and next values of the registered pulse outputs.
   always_comb begin
      state_d    = state_q;
      base_en_d  = 1'b0;
      extra_en_d = 1'b0;
      err_ill_d  = 1'b0;
      err_to_d   = 1'b0;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  state_d    = WAIT;
                  base_en_d  = (issue_funct7 == BASE_F7);
                  extra_en_d = (issue_funct7 != BASE_F7);
               end else begin
                  err_ill_d = 1'b1;
               end
            end
         end
         WAIT: begin
            // A done on the final cycle still wins over the timeout.
            if (sel_done) begin
               capture = (rd_q != 5'd0);
               state_d = (rd_q != 5'd0) ? HOLD : IDLE;
            end else if (expired) begin
               err_to_d = 1'b1;
               state_d  = IDLE;
            end
         end
         HOLD: begin
            if (wb_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Op context latched at accept, result captured on the selected done.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q  <= SEL_BASE;
         rd_q   <= 5'd0;
         data_q <= '0;
      end else begin
         if (accept && legal) begin
            sel_q <= (issue_funct7 == BASE_F7) ? SEL_BASE : SEL_EXTRA;
            rd_q  <= issue_rd;
         end
         if (capture) begin
            data_q <= (sel_q == SEL_BASE) ? base_result : extra_result;
         end
      end
   end

   // Registered enable and error pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base_enable  <= 1'b0;
         extra_enable <= 1'b0;
         err_illegal  <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         base_enable  <= base_en_d;
         extra_enable <= extra_en_d;
         err_illegal  <= err_ill_d;
         err_timeout  <= err_to_d;
      end
   end

   assign issue_ready = (state_q == IDLE);
   assign wb_valid    = (state_q == HOLD);
   assign wb_rd       = rd_q;
   assign wb_data     = data_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_result_collect.sv
// Directed checks of the ALU result collector.
module tb_alu_result_collect;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_ready;
   logic [6:0]  issue_funct7;
   logic [4:0]  issue_rd;
   logic        base_enable, extra_enable;
   logic        base_done, extra_done;
   logic [31:0] base_result, extra_result;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err_illegal, err_timeout;
   alu_state_e  dbg_state;

   int tests_run = 0;
   int tests_failed = 0;

   // Pulse/cycle counters sampled mid-cycle; tests look at deltas.
   int n_base_en = 0, n_extra_en = 0, n_err_ill = 0, n_err_to = 0, n_wb = 0;

   alu_result_collect #(.XLEN(32), .TIMEOUT(16)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_funct7 (issue_funct7),
      .issue_rd     (issue_rd),
      .base_enable  (base_enable),
      .extra_enable (extra_enable),
      .base_done    (base_done),
      .base_result  (base_result),
      .extra_done   (extra_done),
      .extra_result (extra_result),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .err_illegal  (err_illegal),
      .err_timeout  (err_timeout),
      .dbg_state    (dbg_state)
   );

   // Clock generation.
   always #5 clock = ~clock;

   // Pulse monitor on the falling edge, away from output updates.
   always @(negedge clock) begin
      if (base_enable)  n_base_en++;
      if (extra_enable) n_extra_en++;
      if (err_illegal)  n_err_ill++;
      if (err_timeout)  n_err_to++;
      if (wb_valid)     n_wb++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [6:0] f7, input logic [4:0] rd);
      issue_valid  = 1'b1;
      issue_funct7 = f7;
      issue_rd     = rd;
      tick();
      issue_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      issue_valid = 1'b0; issue_funct7 = 7'h00; issue_rd = 5'd0;
      base_done = 1'b0; extra_done = 1'b0;
      base_result = 32'h0; extra_result = 32'h0;
      wb_ready = 1'b1;
      #12;
      tests_run++;
      if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
      tests_run++;
      if ({base_enable, extra_enable, wb_valid, err_illegal, err_timeout} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b want 00000", {base_enable, extra_enable, wb_valid, err_illegal, err_timeout});
      end
      tests_run++;
      if (wb_data !== 32'h0 || wb_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_wb_regs: got rd=%0d data=%h want 0/0", wb_rd, wb_data); end
      @(negedge clock);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_base_op();
      int be0, ee0, wb0;
      be0 = n_base_en; ee0 = n_extra_en; wb0 = n_wb;
      wb_ready = 1'b1;
      issue(7'h00, 5'd5);
      tests_run++;
      if (base_enable !== 1'b1) begin tests_failed++; $display("FAIL base_enable_latency: got %b want 1", base_enable); end
      tick(); tick(); tick();
      base_done = 1'b1; base_result = 32'h1234_5678;
      tick();
      base_done = 1'b0; base_result = 32'h0;
      tests_run++;
      if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL base_wb_latency: got %b want 1", wb_valid); end
      tests_run++;
      if (wb_rd !== 5'd5 || wb_data !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL base_wb_payload: got rd=%0d data=%h want 5/12345678", wb_rd, wb_data);
      end
      tick();
      tests_run++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
         tests_failed++; $display("FAIL base_return_idle: got wb_valid=%b ready=%b want 0/1", wb_valid, issue_ready);
      end
      tests_run++;
      if (n_base_en - be0 != 1 || n_extra_en - ee0 != 0 || n_wb - wb0 != 1) begin
         tests_failed++;
         $display("FAIL base_pulse_counts: got be=%0d ee=%0d wb=%0d want 1/0/1", n_base_en - be0, n_extra_en - ee0, n_wb - wb0);
      end
   endtask

   task automatic test_extra_backpressure();
      int ee0, wb0;
      ee0 = n_extra_en; wb0 = n_wb;
      wb_ready = 1'b0;
      issue(7'h20, 5'd7);
      tests_run++;
      if (extra_enable !== 1'b1 || base_enable !== 1'b0) begin
         tests_failed++; $display("FAIL extra_enable: got extra=%b base=%b want 1/0", extra_enable, base_enable);
      end
      tick();
      extra_done = 1'b1; extra_result = 32'hDEAD_BEEF;
      tick();
      extra_done = 1'b0; extra_result = 32'h0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_rd !== 5'd7 || issue_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL extra_hold_%0d: got v=%b rd=%0d data=%h ready=%b want 1/7/deadbeef/0", i, wb_valid, wb_rd, wb_data, issue_ready);
         end
         tick();
      end
      wb_ready = 1'b1;
      tests_run++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin
         tests_failed++; $display("FAIL extra_hold_last: got v=%b data=%h want 1/deadbeef", wb_valid, wb_data);
      end
      tick();
      tests_run++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || dbg_state !== IDLE) begin
         tests_failed++; $display("FAIL extra_release: got v=%b ready=%b state=%0d want 0/1/IDLE", wb_valid, issue_ready, dbg_state);
      end
      tests_run++;
      if (n_wb - wb0 != 5 || n_extra_en - ee0 != 1) begin
         tests_failed++; $display("FAIL extra_counts: got wb=%0d ee=%0d want 5/1", n_wb - wb0, n_extra_en - ee0);
      end
   endtask

   task automatic test_illegal();
      int be0, ee0, ei0;
      be0 = n_base_en; ee0 = n_extra_en; ei0 = n_err_ill;
      issue(7'h01, 5'd3);
      tests_run++;
      if (err_illegal !== 1'b1 || issue_ready !== 1'b1) begin
         tests_failed++; $display("FAIL illegal_pulse: got err=%b ready=%b want 1/1", err_illegal, issue_ready);
      end
      tick();
      tests_run++;
      if (err_illegal !== 1'b0 || issue_ready !== 1'b1) begin
         tests_failed++; $display("FAIL illegal_single: got err=%b ready=%b want 0/1", err_illegal, issue_ready);
      end
      tests_run++;
      if (n_err_ill - ei0 != 1 || n_base_en - be0 != 0 || n_extra_en - ee0 != 0) begin
         tests_failed++; $display("FAIL illegal_counts: got ei=%0d be=%0d ee=%0d want 1/0/0", n_err_ill - ei0, n_base_en - be0, n_extra_en - ee0);
      end
   endtask

   task automatic test_timeout();
      int wb0, et0;
      logic early;
      wb0 = n_wb; et0 = n_err_to; early = 1'b0;
      wb_ready = 1'b1;
      issue(7'h00, 5'd9);
      for (int k = 1; k <= 15; k++) begin
         extra_done   = (k == 2 || k == 9);
         extra_result = 32'hBAD0_0000;
         tick();
         if (err_timeout !== 1'b0 || issue_ready !== 1'b0) early = 1'b1;
      end
      extra_done = 1'b0;
      tests_run++;
      if (early) begin tests_failed++; $display("FAIL timeout_early: got early exit/err=1 want WAIT for 16 cycles"); end
      tick();
      tests_run++;
      if (err_timeout !== 1'b1 || issue_ready !== 1'b1) begin
         tests_failed++; $display("FAIL timeout_pulse: got err=%b ready=%b want 1/1", err_timeout, issue_ready);
      end
      tick();
      tests_run++;
      if (err_timeout !== 1'b0 || n_err_to - et0 != 1 || n_wb - wb0 != 0) begin
         tests_failed++; $display("FAIL timeout_single: got err=%b pulses=%0d wb=%0d want 0/1/0", err_timeout, n_err_to - et0, n_wb - wb0);
      end
   endtask

   task automatic test_done_at_timeout();
      int et0;
      et0 = n_err_to;
      wb_ready = 1'b1;
      issue(7'h00, 5'd4);
      for (int k = 1; k <= 15; k++) tick();
      base_done = 1'b1; base_result = 32'hCAFE_0015;
      tick();
      base_done = 1'b0;
      tests_run++;
      if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_0015 || err_timeout !== 1'b0) begin
         tests_failed++; $display("FAIL late_done: got v=%b data=%h err=%b want 1/cafe0015/0", wb_valid, wb_data, err_timeout);
      end
      tick();
      tests_run++;
      if (n_err_to - et0 != 0 || issue_ready !== 1'b1) begin
         tests_failed++; $display("FAIL late_done_noerr: got errs=%0d ready=%b want 0/1", n_err_to - et0, issue_ready);
      end
   endtask

   task automatic test_rd_zero();
      int wb0;
      wb0 = n_wb;
      issue(7'h00, 5'd0);
      tick();
      base_done = 1'b1; base_result = 32'h0000_0BAD;
      tick();
      base_done = 1'b0;
      tests_run++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || dbg_state !== IDLE) begin
         tests_failed++; $display("FAIL rd0_idle: got v=%b ready=%b state=%0d want 0/1/IDLE", wb_valid, issue_ready, dbg_state);
      end
      tick();
      tests_run++;
      if (n_wb - wb0 != 0) begin tests_failed++; $display("FAIL rd0_no_wb: got %0d wb cycles want 0", n_wb - wb0); end
   endtask

   task automatic test_reset_in_hold();
      int et0;
      et0 = n_err_to;
      wb_ready = 1'b0;
      issue(7'h20, 5'd12);
      extra_done = 1'b1; extra_result = 32'h5555_AAAA;
      tick();
      extra_done = 1'b0;
      tests_run++;
      if (wb_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_before_reset: got %b want 1", wb_valid); end
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || wb_data !== 32'h0 || err_timeout !== 1'b0) begin
         tests_failed++; $display("FAIL reset_abort: got v=%b ready=%b data=%h err=%b want 0/1/0/0", wb_valid, issue_ready, wb_data, err_timeout);
      end
      wb_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      tick();
      tests_run++;
      if (wb_valid !== 1'b0 || issue_ready !== 1'b1 || n_err_to - et0 != 0) begin
         tests_failed++; $display("FAIL post_reset_idle: got v=%b ready=%b errs=%0d want 0/1/0", wb_valid, issue_ready, n_err_to - et0);
      end
   endtask

   initial begin
      test_reset();
      test_base_op();
      test_extra_backpressure();
      test_illegal();
      test_timeout();
      test_done_at_timeout();
      test_rd_zero();
      test_reset_in_hold();
      test_base_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
